mbist_addr_seq: RTL and testbench
=================================

// Module: mbist_addr_seq
// PURPOSE
//  Parametrised MBIST address sequencer. Walks an address window [lo_addr,hi_addr] for a
//  programmable number of passes. Modes: linear up, linear down, or ping-pong (direction
//  reverses each pass). Supports column-fast or row-fast ordering.
//  Sits between the MBIST controller (start/step/abort) and the memory address mux.
// PARAMETERS
//  ADDR_W  12  address width; addr = {row, col}
//  ROW_W   6   row field width (upper bits of addr); COL_W = ADDR_W-ROW_W, 1 <= ROW_W < ADDR_W
//  PASS_W  4   width of pass count/config
// PORTS
//  clk       in   1       clock, rising edge
//  reset     in   1       synchronous, active-high; dominates all other inputs
//  start     in   1       begin sequence; accepted only in IDLE
//  mode      in   2       00 up, 01 down, 10 ping-pong up-first, 11 ping-pong down-first
//  row_fast  in   1       1: row field increments fastest
//  lo_addr   in   ADDR_W  window low bound (traversal index space)
//  hi_addr   in   ADDR_W  window high bound (traversal index space)
//  num_pass  in   PASS_W  passes to run; 0 treated as 1
//  step      in   1       advance enable; sampled only when addr_vld=1
//  abort     in   1       terminate RUN without done
//  addr      out  ADDR_W  current address
//  addr_vld  out  1       addr valid (state RUN)
//  dir       out  1       1 = ascending, 0 = descending
//  last      out  1       addr_vld & addr is final index of current pass
//  pass_cnt  out  PASS_W  current pass index, 0-based
//  busy      out  1       state RUN
//  done      out  1       one-cycle pulse at normal completion
//  cfg_err   out  1       sticky: last start had lo_addr > hi_addr
// BEHAVIOUR
//  - reset: state IDLE, all outputs 0 (addr, dir, pass_cnt, cfg_err included).
//  - FSM IDLE -> RUN -> DONE -> IDLE. abort: RUN -> IDLE.
//  - Config (mode, row_fast, lo, hi, num_pass) latched on accepted start.
//    Inputs ignored for the rest of the sequence.
//  - Internal index i (ADDR_W bits). addr = row_fast ? {i[ROW_W-1:0], i[ADDR_W-1:ROW_W]} : i.
//    Bounds compare on i, never on addr.
//  - IDLE + start, lo>hi: cfg_err<=1, stay IDLE, no busy/done.
//  - IDLE + start, lo<=hi: cfg_err<=0, pass_cnt<=0.
//    dir<=1, i<=lo for modes 00/10; dir<=0, i<=hi for modes 01/11.
//    Next cycle: RUN, busy=1, addr_vld=1 (1-cycle latency).
//  - RUN, step=0: all outputs hold.
//  - RUN, step=1, !last: i<=i+1 (dir=1) or i-1 (dir=0); new addr next cycle.
//    No wrap: last bounds i to [lo,hi].
//  - RUN, step=1, last, pass_cnt < max(num_pass,1)-1: pass_cnt++.
//    Linear modes: i reloads start bound, dir unchanged.
//    Ping-pong: dir toggles, i unchanged, so the endpoint is emitted twice (end of pass n, start of pass n+1).
//  - RUN, step=1, last, final pass: -> DONE.
//    DONE: done=1, busy=0, addr_vld=0 for exactly one cycle, then IDLE. start in DONE ignored.
//  - lo==hi: every address is last; each step ends a pass.
//  - abort (priority over step) in RUN: next cycle IDLE, busy=0, addr_vld=0, done=0.
//    addr/dir/pass_cnt hold last values.
//  - start while busy or in DONE: ignored. In IDLE, addr/dir/pass_cnt hold last values.
// TESTING (bench ADDR_W=4, ROW_W=2, PASS_W=4)
//  1. mode=00 lo=2 hi=5 num_pass=1, step=1 -> addr 2,3,4,5, last on 5 only;
//     next cycle done=1, busy=0.
//  2. mode=10 lo=0 hi=3 num_pass=3 -> addr 0,1,2,3,3,2,1,0,0,1,2,3;
//     dir 1/0/1 by pass, pass_cnt 0/1/2; single done pulse.
//  3. mode=00 row_fast=1 lo=0 hi=5 -> addr 0,4,8,12,1,5.
//  4. start lo=6 hi=3 -> cfg_err=1, busy/done stay 0;
//     then start lo=0 hi=1 -> cfg_err=0, sequence 0,1.
//  5. mode=01 lo=hi=7 num_pass=0 -> one cycle addr=7, dir=0, last=1; then done.
//  6. mid-run: step=0 holds addr for 3 cycles; abort -> busy=0 next cycle, no done.
//     Reset mid-run -> all outputs 0 next cycle.

Source files
------------

// File: rtl/mbist_addr_seq.sv
// ---------------------------------------------------------------------------
// mbist_addr_seq
// Purpose : MBIST address sequencer. Walks the index window [lo_addr,hi_addr]
//           for a programmable number of passes, ascending, descending or
//           ping-pong, with optional row-fast address scrambling.
// Ports   :
//   clk       in   clock, rising edge
//   reset     in   synchronous, active-high; dominates all other inputs
//   start     in   begin a sequence (accepted only in IDLE)
//   mode      in   00 up, 01 down, 10 ping-pong up-first, 11 ping-pong down-first
//   row_fast  in   1: row field increments fastest
//   lo_addr   in   window low bound (index space)
//   hi_addr   in   window high bound (index space)
//   num_pass  in   passes to run; 0 behaves as 1
//   step      in   advance enable, honoured only while addr_vld=1
//   abort     in   terminate RUN without done
//   addr      out  current memory address
//   addr_vld  out  address valid (RUN)
//   dir       out  1 ascending, 0 descending
//   last      out  addr_vld and index is the final one of the current pass
//   pass_cnt  out  current pass, 0-based
//   busy      out  RUN
//   done      out  one-cycle pulse on normal completion
//   cfg_err   out  sticky: last start had lo_addr > hi_addr
// ---------------------------------------------------------------------------
module mbist_addr_seq #(
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned ROW_W  = 6,
    parameter int unsigned PASS_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic              row_fast,
    input  logic [ADDR_W-1:0] lo_addr,
    input  logic [ADDR_W-1:0] hi_addr,
    input  logic [PASS_W-1:0] num_pass,
    input  logic              step,
    input  logic              abort,
    output logic [ADDR_W-1:0] addr,
    output logic              addr_vld,
    output logic              dir,
    output logic              last,
    output logic [PASS_W-1:0] pass_cnt,
    output logic              busy,
    output logic              done,
    output logic              cfg_err
);

    localparam int unsigned COL_W = ADDR_W - ROW_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Traversal index and per-sequence configuration
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] lo_q;
    logic [ADDR_W-1:0] hi_q;
    logic [PASS_W-1:0] pass_max_q;
    logic              pingpong_q;
    logic              row_fast_q;
    logic              dir_q;
    logic [PASS_W-1:0] pass_q;
    logic              cfg_err_q;

    logic start_ok;
    logic at_end;
    logic final_pass;

    assign start_ok   = start && (lo_addr <= hi_addr);
    // End of pass is judged on the index in the current direction of travel
    assign at_end     = dir_q ? (idx == hi_q) : (idx == lo_q);
    assign final_pass = (pass_q == pass_max_q);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; abort takes priority over step
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start_ok) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (step && at_end && final_pass) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State-decoded outputs
    always_comb begin
        busy     = 1'b0;
        addr_vld = 1'b0;
        done     = 1'b0;
        case (state)
            S_RUN: begin
                busy     = 1'b1;
                addr_vld = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy     = 1'b0;
            end
        endcase
    end

    // Datapath: config capture, index walk and pass accounting
    always_ff @(posedge clk) begin
        if (reset) begin
            idx        <= '0;
            lo_q       <= '0;
            hi_q       <= '0;
            pass_max_q <= '0;
            pingpong_q <= 1'b0;
            row_fast_q <= 1'b0;
            dir_q      <= 1'b0;
            pass_q     <= '0;
            cfg_err_q  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (lo_addr > hi_addr) begin
                            // Rejected start leaves the previous address view intact
                            cfg_err_q <= 1'b1;
                        end else begin
                            cfg_err_q  <= 1'b0;
                            lo_q       <= lo_addr;
                            hi_q       <= hi_addr;
                            pingpong_q <= mode[1];
                            row_fast_q <= row_fast;
                            pass_q     <= '0;
                            pass_max_q <= (num_pass == '0) ? '0
                                                           : num_pass - PASS_W'(1);
                            dir_q      <= ~mode[0];
                            idx        <= mode[0] ? hi_addr : lo_addr;
                        end
                    end
                end
                S_RUN: begin
                    if (!abort && step) begin
                        if (!at_end) begin
                            idx <= dir_q ? idx + ADDR_W'(1) : idx - ADDR_W'(1);
                        end else if (!final_pass) begin
                            pass_q <= pass_q + PASS_W'(1);
                            if (pingpong_q) begin
                                // Endpoint is re-emitted as the first address of the next pass
                                dir_q <= ~dir_q;
                            end else begin
                                idx <= dir_q ? lo_q : hi_q;
                            end
                        end
                    end
                end
                default: begin
                    idx <= idx;
                end
            endcase
        end
    end

    // Row-fast view swaps the fields so the low index bits drive the row
    assign addr     = row_fast_q ? {idx[ROW_W-1:0], idx[ROW_W +: COL_W]} : idx;
    assign dir      = dir_q;
    assign pass_cnt = pass_q;
    assign cfg_err  = cfg_err_q;
    assign last     = (state == S_RUN) && at_end;

endmodule

// File: tb/tb_mbist_addr_seq.sv
module tb_mbist_addr_seq;

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned ROW_W  = 2;
    localparam int unsigned PASS_W = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [1:0]        mode;
    logic              row_fast;
    logic [ADDR_W-1:0] lo_addr;
    logic [ADDR_W-1:0] hi_addr;
    logic [PASS_W-1:0] num_pass;
    logic              step;
    logic              abort;
    logic [ADDR_W-1:0] addr;
    logic              addr_vld;
    logic              dir;
    logic              last;
    logic [PASS_W-1:0] pass_cnt;
    logic              busy;
    logic              done;
    logic              cfg_err;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic              d;
        logic              l;
        logic [PASS_W-1:0] p;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   done_cnt = 0;

    mbist_addr_seq #(.ADDR_W(ADDR_W), .ROW_W(ROW_W), .PASS_W(PASS_W)) dut (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .row_fast(row_fast),
        .lo_addr(lo_addr), .hi_addr(hi_addr), .num_pass(num_pass), .step(step),
        .abort(abort), .addr(addr), .addr_vld(addr_vld), .dir(dir), .last(last),
        .pass_cnt(pass_cnt), .busy(busy), .done(done), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int a, input bit d, input bit l, input int p);
        exp_t e;
        e.a = ADDR_W'(a);
        e.d = d;
        e.l = l;
        e.p = PASS_W'(p);
        exp_q.push_back(e);
    endtask

    task automatic start_seq(input logic [1:0] m, input bit rf, input int lo, input int hi,
                             input int np);
        mode     = m;
        row_fast = rf;
        lo_addr  = ADDR_W'(lo);
        hi_addr  = ADDR_W'(hi);
        num_pass = PASS_W'(np);
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    // Bounded wait for one done pulse, then confirm it was a single pulse
    task automatic wait_done(input string name);
        int d0;
        d0 = done_cnt;
        for (int k = 0; k < 64 && done_cnt == d0; k++) tick();
        check({name, "_done"}, done_cnt, d0 + 1);
        tick();
        tick();
        check({name, "_single_done"}, done_cnt, d0 + 1);
        check({name, "_idle_busy"}, busy, 0);
        check({name, "_sb_drain"}, exp_q.size(), 0);
    endtask

    // Scoreboard: every address consumed by a step is compared against the queue
    always @(negedge clk) begin
        if (!reset) begin
            if (done) begin
                done_cnt++;
                check("done_busy", busy, 0);
                check("done_vld", addr_vld, 0);
            end
            if (addr_vld && step && !abort) begin
                if (exp_q.size() == 0) begin
                    check("sb_underflow", exp_q.size(), 1);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("sb_addr", addr, e.a);
                    check("sb_dir", dir, e.d);
                    check("sb_last", last, e.l);
                    check("sb_pass", pass_cnt, e.p);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; start = 1'b0; mode = 2'b00; row_fast = 1'b0;
        lo_addr = '0; hi_addr = '0; num_pass = '0; step = 1'b0; abort = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("rst_addr", addr, 0);
        check("rst_vld", addr_vld, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cfg_err", cfg_err, 0);
        check("rst_pass", pass_cnt, 0);
        check("rst_dir", dir, 0);

        // 1: linear up 2..5
        for (int a = 2; a <= 5; a++) push(a, 1'b1, a == 5, 0);
        step = 1'b1;
        start_seq(2'b00, 1'b0, 2, 5, 1);
        wait_done("t1");

        // 2: ping-pong up-first, three passes
        for (int a = 0; a <= 3; a++) push(a, 1'b1, a == 3, 0);
        for (int a = 3; a >= 0; a--) push(a, 1'b0, a == 0, 1);
        for (int a = 0; a <= 3; a++) push(a, 1'b1, a == 3, 2);
        start_seq(2'b10, 1'b0, 0, 3, 3);
        wait_done("t2");

        // 3: row-fast ordering
        push(0, 1'b1, 1'b0, 0);
        push(4, 1'b1, 1'b0, 0);
        push(8, 1'b1, 1'b0, 0);
        push(12, 1'b1, 1'b0, 0);
        push(1, 1'b1, 1'b0, 0);
        push(5, 1'b1, 1'b1, 0);
        start_seq(2'b00, 1'b1, 0, 5, 1);
        wait_done("t3");

        // 4: bad window rejected, then a good one clears cfg_err
        start_seq(2'b00, 1'b0, 6, 3, 1);
        check("t4_cfg_err", cfg_err, 1);
        check("t4_busy", busy, 0);
        check("t4_done", done, 0);
        check("t4_addr_hold", addr, 5);
        tick();
        check("t4_still_idle", busy, 0);
        push(0, 1'b1, 1'b0, 0);
        push(1, 1'b1, 1'b1, 0);
        start_seq(2'b00, 1'b0, 0, 1, 1);
        check("t4_cfg_clr", cfg_err, 0);
        wait_done("t4");

        // 5: single-address window, down, num_pass=0
        push(7, 1'b0, 1'b1, 0);
        start_seq(2'b01, 1'b0, 7, 7, 0);
        wait_done("t5");

        // 6: hold with step=0, then abort
        step = 1'b0;
        start_seq(2'b00, 1'b0, 0, 15, 1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t6_hold0", addr, 0);
            check("t6_hold0_vld", addr_vld, 1);
        end
        push(0, 1'b1, 1'b0, 0);
        push(1, 1'b1, 1'b0, 0);
        step = 1'b1;
        tick();
        tick();
        step = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t6_hold2", addr, 2);
        end
        begin
            int d0;
            d0 = done_cnt;
            abort = 1'b1;
            tick();
            abort = 1'b0;
            check("t6_abort_busy", busy, 0);
            check("t6_abort_vld", addr_vld, 0);
            check("t6_abort_done", done, 0);
            check("t6_abort_addr", addr, 2);
            check("t6_abort_dir", dir, 1);
            tick();
            check("t6_abort_no_done", done_cnt, d0);
        end

        // Reset mid-run clears every output
        push(9, 1'b0, 1'b0, 0);
        step = 1'b1;
        start_seq(2'b01, 1'b0, 3, 9, 2);
        tick();
        check("t6_run_addr", addr, 8);
        reset = 1'b1;
        step = 1'b0;
        tick();
        check("rst2_addr", addr, 0);
        check("rst2_vld", addr_vld, 0);
        check("rst2_busy", busy, 0);
        check("rst2_dir", dir, 0);
        check("rst2_pass", pass_cnt, 0);
        check("rst2_done", done, 0);
        reset = 1'b0;
        tick();
        check("final_sb_drain", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
